// File: rtl/sd_buf_arbiter_if.sv
// Request/response bundle for one Wishbone-style master of the SD DMA buffer.
// The arbiter takes the slave side; a bridge or DMA engine takes the master side.
interface sd_buf_arbiter_if;
    logic        cyc;
    logic        stb;
    logic        we;
    logic [3:0]  sel;
    logic [31:0] addr;
    logic [31:0] din;
    logic [31:0] dout;
    logic        ack;
    logic        err;

    modport master (output cyc, stb, we, sel, addr, din, input dout, ack, err);
    modport slave  (input cyc, stb, we, sel, addr, din, output dout, ack, err);
endinterface

// File: rtl/sd_buf_arbiter.sv
// Shares one single-port SD DMA buffer RAM between the CPU bridge (m0) and the
// SD controller DMA master (m1) using an arbitrate/access/acknowledge sequence.
module sd_buf_arbiter #(
    parameter int AW         = 10,
    parameter bit FIXED_PRIO = 1'b0
) (
    input  logic              clkCPU,
    input  logic              globlRst,
    sd_buf_arbiter_if.slave   m0,
    sd_buf_arbiter_if.slave   m1,
    output logic              ram_en,
    output logic [3:0]        ram_we,
    output logic [AW-1:0]     ram_addr,
    output logic [31:0]       ram_wdata,
    input  logic [31:0]       ram_rdata,
    output logic [1:0]        grant,
    output logic              busy
);
    // state  | meaning
    // IDLE   | no transaction in flight; arbitrate pending requests
    // ACCESS | RAM driven from the latched request, or range error recorded
    // ACK    | single-cycle ack/err to the owner; read data shown from the RAM
    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        ACK    = 2'd2
    } state_t;

    state_t          state_q, state_d;
    logic            req0, req1;
    logic            range0, range1;
    logic            win1;
    logic            load;

    logic [1:0]      grant_q;
    logic            we_q;
    logic [3:0]      sel_q;
    logic [AW-1:0]   addr_q;
    logic [31:0]     din_q;
    logic            oor_q;
    logic            err_q;
    logic            last1_q;
    logic [31:0]     dout0_q, dout1_q;

    // The RAM is word addressed, so the byte offset bits carry no information.
    logic            unused_bits;
    assign unused_bits = &{1'b0, m0.addr[1:0], m1.addr[1:0]};

    assign req0   = m0.cyc & m0.stb;
    assign req1   = m1.cyc & m1.stb;
    assign range0 = (m0.addr[31:AW+2] == '0);
    assign range1 = (m1.addr[31:AW+2] == '0);

    // m1 wins when alone, or on a tie when round-robin says m0 went last.
    assign win1 = req1 & (~req0 | ((FIXED_PRIO == 1'b0) & ~last1_q));

    always_ff @(posedge clkCPU or negedge globlRst) begin
        if (!globlRst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        load    = 1'b0;
        ram_en  = 1'b0;
        ram_we  = 4'b0000;
        m0.ack  = 1'b0;
        m0.err  = 1'b0;
        m1.ack  = 1'b0;
        m1.err  = 1'b0;
        m0.dout = dout0_q;
        m1.dout = dout1_q;
        case (state_q)
            IDLE: begin
                if (req0 | req1) begin
                    state_d = ACCESS;
                    load    = 1'b1;
                end
            end
            ACCESS: begin
                state_d = ACK;
                ram_en  = ~oor_q;
                ram_we  = (~oor_q & we_q) ? sel_q : 4'b0000;
            end
            ACK: begin
                state_d = IDLE;
                m0.ack  = grant_q[0] & ~err_q & m0.cyc;
                m0.err  = grant_q[0] &  err_q & m0.cyc;
                m1.ack  = grant_q[1] & ~err_q & m1.cyc;
                m1.err  = grant_q[1] &  err_q & m1.cyc;
                if (grant_q[0] & ~err_q) begin
                    m0.dout = ram_rdata;
                end
                if (grant_q[1] & ~err_q) begin
                    m1.dout = ram_rdata;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clkCPU or negedge globlRst) begin
        if (!globlRst) begin
            grant_q <= 2'b00;
            we_q    <= 1'b0;
            sel_q   <= 4'b0000;
            addr_q  <= '0;
            din_q   <= '0;
            oor_q   <= 1'b0;
            err_q   <= 1'b0;
            last1_q <= 1'b1;
            dout0_q <= '0;
            dout1_q <= '0;
        end else begin
            if (load) begin
                grant_q <= win1 ? 2'b10 : 2'b01;
                we_q    <= win1 ? m1.we : m0.we;
                sel_q   <= win1 ? m1.sel : m0.sel;
                addr_q  <= win1 ? m1.addr[AW+1:2] : m0.addr[AW+1:2];
                din_q   <= win1 ? m1.din : m0.din;
                oor_q   <= win1 ? ~range1 : ~range0;
                err_q   <= 1'b0;
            end
            if (state_q == ACCESS) begin
                err_q <= oor_q;
            end
            // Read data is kept after the ack so dout holds between transactions.
            if (state_q == ACK) begin
                last1_q <= grant_q[1];
                grant_q <= 2'b00;
                err_q   <= 1'b0;
                if (grant_q[0] & ~err_q) begin
                    dout0_q <= ram_rdata;
                end
                if (grant_q[1] & ~err_q) begin
                    dout1_q <= ram_rdata;
                end
            end
        end
    end

    assign ram_addr  = addr_q;
    assign ram_wdata = din_q;
    assign grant     = grant_q;
    assign busy      = (state_q != IDLE);
endmodule

// File: tb/tb_sd_buf_arbiter.sv
// Bench for sd_buf_arbiter: directed cases plus randomized two-master traffic
// checked against a transaction-level memory and arbitration model.
module tb_sd_buf_arbiter;
    localparam int AW = 10;

    logic clk = 1'b0;
    always #5 clk = ~clk;
    logic rst_n;

    sd_buf_arbiter_if m0_bus ();
    sd_buf_arbiter_if m1_bus ();
    sd_buf_arbiter_if f0_bus ();
    sd_buf_arbiter_if f1_bus ();

    logic          ram_en, busy;
    logic [3:0]    ram_we;
    logic [AW-1:0] ram_addr;
    logic [31:0]   ram_wdata, ram_rdata;
    logic [1:0]    grant;

    logic          fp_ram_en, fp_busy;
    logic [3:0]    fp_ram_we;
    logic [AW-1:0] fp_ram_addr;
    logic [31:0]   fp_ram_wdata, fp_rdata;
    logic [1:0]    fp_grant;
    assign fp_rdata = 32'h0;

    sd_buf_arbiter #(.AW(AW), .FIXED_PRIO(1'b0)) dut (
        .clkCPU(clk), .globlRst(rst_n), .m0(m0_bus), .m1(m1_bus),
        .ram_en(ram_en), .ram_we(ram_we), .ram_addr(ram_addr), .ram_wdata(ram_wdata),
        .ram_rdata(ram_rdata), .grant(grant), .busy(busy)
    );

    sd_buf_arbiter #(.AW(AW), .FIXED_PRIO(1'b1)) dut_fp (
        .clkCPU(clk), .globlRst(rst_n), .m0(f0_bus), .m1(f1_bus),
        .ram_en(fp_ram_en), .ram_we(fp_ram_we), .ram_addr(fp_ram_addr), .ram_wdata(fp_ram_wdata),
        .ram_rdata(fp_rdata), .grant(fp_grant), .busy(fp_busy)
    );

    // Synchronous read-first buffer RAM
    logic [31:0] mem [0:(1<<AW)-1];
    always @(posedge clk) begin
        if (ram_en) begin
            for (int i = 0; i < 4; i++) begin
                if (ram_we[i]) mem[ram_addr][8*i +: 8] <= ram_wdata[8*i +: 8];
            end
            ram_rdata <= mem[ram_addr];
        end
    end

    logic [31:0] ref_mem [0:15];
    int n_checks = 0;
    int n_fail   = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] din,
                                          input logic [3:0] sel);
        logic [31:0] r;
        r = old;
        for (int i = 0; i < 4; i++) if (sel[i]) r[8*i +: 8] = din[8*i +: 8];
        return r;
    endfunction

    task automatic model_write(input logic [31:0] addr, input logic [3:0] sel, input logic [31:0] din);
        ref_mem[addr[5:2]] = merge(ref_mem[addr[5:2]], din, sel);
    endtask

    task automatic drive(input int id, input logic cyc, input logic stb, input logic we,
                         input logic [3:0] sel, input logic [31:0] addr, input logic [31:0] din);
        if (id == 1) begin
            m1_bus.cyc = cyc; m1_bus.stb = stb; m1_bus.we = we;
            m1_bus.sel = sel; m1_bus.addr = addr; m1_bus.din = din;
        end else begin
            m0_bus.cyc = cyc; m0_bus.stb = stb; m0_bus.we = we;
            m0_bus.sel = sel; m0_bus.addr = addr; m0_bus.din = din;
        end
    endtask

    function automatic logic bus_ack(input int id);
        return (id == 1) ? m1_bus.ack : m0_bus.ack;
    endfunction
    function automatic logic bus_err(input int id);
        return (id == 1) ? m1_bus.err : m0_bus.err;
    endfunction
    function automatic logic [31:0] bus_dout(input int id);
        return (id == 1) ? m1_bus.dout : m0_bus.dout;
    endfunction

    // Results of the last directed transaction
    logic [31:0]   t_rd;
    logic          t_ack, t_err, t_en;
    logic [3:0]    t_we;
    logic [AW-1:0] t_addr;
    logic [1:0]    t_grant;
    int            t_lat;

    task automatic do_txn(input int id, input logic we, input logic [3:0] sel,
                          input logic [31:0] addr, input logic [31:0] din, input bit abort);
        t_rd = '0; t_ack = 1'b0; t_err = 1'b0; t_lat = 0;
        t_en = 1'b0; t_we = '0; t_addr = '0; t_grant = '0;
        @(negedge clk);
        drive(id, 1'b1, 1'b1, we, sel, addr, din);
        for (int i = 1; i <= 6 && t_lat == 0; i++) begin
            @(negedge clk);
            if (i == 1) begin
                t_en = ram_en; t_we = ram_we; t_addr = ram_addr; t_grant = grant;
                if (abort) drive(id, 1'b0, 1'b0, we, sel, addr, din);
            end
            if (bus_ack(id) | bus_err(id)) begin
                t_ack = bus_ack(id); t_err = bus_err(id); t_rd = bus_dout(id); t_lat = i;
            end
        end
        drive(id, 1'b0, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
    endtask

    // Randomized-phase state
    logic [1:0]  act, prev_req, prev_grant, exp_g, g;
    logic        r_we [2];
    logic [3:0]  r_sel [2];
    logic [31:0] r_addr [2];
    logic [31:0] r_din [2];
    logic        last_owner, exp_err;
    int          start_c, n_acks, prev_c, exp_owner, idx, fp_acks;
    logic [31:0] a;

    initial begin
        rst_n = 1'b0;
        drive(0, 0, 0, 0, 4'h0, 32'h0, 32'h0);
        drive(1, 0, 0, 0, 4'h0, 32'h0, 32'h0);
        f0_bus.cyc = 0; f0_bus.stb = 0; f0_bus.we = 0; f0_bus.sel = 4'h0; f0_bus.addr = 0; f0_bus.din = 0;
        f1_bus.cyc = 0; f1_bus.stb = 0; f1_bus.we = 0; f1_bus.sel = 4'h0; f1_bus.addr = 0; f1_bus.din = 0;
        repeat (2) @(negedge clk);
        chk("rst_grant", 32'(grant), 0);
        chk("rst_busy", 32'(busy), 0);
        chk("rst_ram_en", 32'(ram_en), 0);
        chk("rst_ram_we", 32'(ram_we), 0);
        chk("rst_ram_addr", 32'(ram_addr), 0);
        chk("rst_ram_wdata", ram_wdata, 0);
        chk("rst_m0_dout", m0_bus.dout, 0);
        chk("rst_m1_dout", m1_bus.dout, 0);
        chk("rst_resp", 32'({m0_bus.ack, m0_bus.err, m1_bus.ack, m1_bus.err}), 0);
        @(negedge clk);
        rst_n = 1'b1;

        // m0 full-word write then read back
        do_txn(0, 1'b1, 4'hF, 32'h0000_0010, 32'hDEAD_BEEF, 1'b0);
        model_write(32'h10, 4'hF, 32'hDEAD_BEEF);
        chk("wr_lat", 32'(t_lat), 2);
        chk("wr_ack", 32'({t_ack, t_err}), 32'b10);
        chk("wr_ram_we", 32'({t_en, t_we}), 32'h1F);
        chk("wr_ram_addr", 32'(t_addr), 4);
        chk("wr_grant", 32'(t_grant), 32'b01);
        do_txn(0, 1'b0, 4'h0, 32'h0000_0010, 32'h0, 1'b0);
        chk("rd_lat", 32'(t_lat), 2);
        chk("rd_data", t_rd, 32'hDEAD_BEEF);

        // Fill the working window so every later read has a known value
        for (int i = 0; i < 16; i++) begin
            if (i != 4) begin
                a = $urandom;
                do_txn(i % 2, 1'b1, 4'hF, 32'(i) << 2, a, 1'b0);
                model_write(32'(i) << 2, 4'hF, a);
                chk("fill_ack", 32'({t_ack, t_err}), 32'b10);
            end
        end

        // m1 byte-lane write
        do_txn(1, 1'b1, 4'hF, 32'h20, 32'h1122_3344, 1'b0);
        model_write(32'h20, 4'hF, 32'h1122_3344);
        do_txn(1, 1'b1, 4'b0010, 32'h20, 32'h0000_AB00, 1'b0);
        model_write(32'h20, 4'b0010, 32'h0000_AB00);
        chk("lane_ram_we", 32'(t_we), 32'b0010);
        do_txn(1, 1'b0, 4'h0, 32'h20, 32'h0, 1'b0);
        chk("lane_rd_data", t_rd, 32'h1122_AB44);

        // Out-of-range read
        do_txn(0, 1'b0, 4'hF, 32'h0000_1000, 32'h0, 1'b0);
        chk("oor_lat", 32'(t_lat), 2);
        chk("oor_resp", 32'({t_ack, t_err}), 32'b01);
        chk("oor_ram_en", 32'({t_en, t_we}), 0);

        // Abort: m1 drops cyc during ACCESS; the write must still land
        do_txn(1, 1'b1, 4'hF, 32'h30, 32'hCAFE_F00D, 1'b1);
        model_write(32'h30, 4'hF, 32'hCAFE_F00D);
        chk("abort_resp", 32'({t_ack, t_err}), 0);
        chk("abort_ram_en", 32'(t_en), 1);
        do_txn(0, 1'b0, 4'h0, 32'h30, 32'h0, 1'b0);
        chk("abort_rd_data", t_rd, 32'hCAFE_F00D);

        // Round-robin contention straight after reset
        @(negedge clk); rst_n = 1'b0;
        @(negedge clk); rst_n = 1'b1;
        drive(0, 1, 1, 0, 4'hF, 32'h10, 32'h0);
        drive(1, 1, 1, 0, 4'hF, 32'h20, 32'h0);
        n_acks = 0; prev_c = 0; exp_owner = 0;
        for (int c = 1; c <= 20; c++) begin
            @(negedge clk);
            if (m0_bus.ack | m1_bus.ack) begin
                chk("rr_single", 32'(m0_bus.ack & m1_bus.ack), 0);
                chk("rr_owner", 32'(m1_bus.ack), 32'(exp_owner));
                chk("rr_spacing", 32'(c - prev_c), (n_acks == 0) ? 2 : 3);
                chk("rr_data", bus_dout(exp_owner), ref_mem[(exp_owner == 1) ? 8 : 4]);
                n_acks++; prev_c = c; exp_owner = 1 - exp_owner;
            end
        end
        chk("rr_acks", 32'(n_acks), 7);
        drive(0, 0, 0, 0, 4'h0, 32'h0, 32'h0);
        drive(1, 0, 0, 0, 4'h0, 32'h0, 32'h0);

        // Fixed-priority contention on the second instance
        @(negedge clk);
        f0_bus.cyc = 1; f0_bus.stb = 1; f0_bus.addr = 32'h40;
        f1_bus.cyc = 1; f1_bus.stb = 1; f1_bus.addr = 32'h44;
        fp_acks = 0;
        for (int c = 1; c <= 15; c++) begin
            @(negedge clk);
            chk("fp_m1_granted", 32'({fp_grant[1], f1_bus.ack}), 0);
            if (f0_bus.ack) fp_acks++;
        end
        chk("fp_m0_acks", 32'(fp_acks), 5);
        f0_bus.cyc = 0; f0_bus.stb = 0; f1_bus.cyc = 0; f1_bus.stb = 0;

        // Asynchronous reset in the middle of ACCESS
        @(negedge clk);
        drive(0, 1, 1, 1, 4'hF, 32'h200, 32'h5555_AAAA);
        @(negedge clk);
        chk("ar_pre_access", 32'({busy, ram_en, grant}), 32'b1101);
        #2 rst_n = 1'b0;
        #1;
        chk("ar_busy", 32'(busy), 0);
        chk("ar_grant", 32'(grant), 0);
        chk("ar_ram", 32'({ram_en, ram_we}), 0);
        chk("ar_ram_addr", 32'(ram_addr), 0);
        chk("ar_ram_wdata", ram_wdata, 0);
        chk("ar_m0_dout", m0_bus.dout, 0);
        drive(0, 0, 0, 0, 4'h0, 32'h0, 32'h0);
        @(negedge clk);
        rst_n = 1'b1;

        // Randomized traffic from both masters
        act = 2'b00; prev_req = 2'b00; prev_grant = 2'b00;
        last_owner = 1'b1; start_c = 0;
        for (int c = 0; c < 430; c++) begin
            @(negedge clk);
            g = grant;
            if (prev_grant == 2'b00) begin
                if (prev_req == 2'b11)      exp_g = last_owner ? 2'b01 : 2'b10;
                else if (prev_req[0])       exp_g = 2'b01;
                else if (prev_req[1])       exp_g = 2'b10;
                else                        exp_g = 2'b00;
                chk("arb_grant", 32'(g), 32'(exp_g));
                if (g != 2'b00) begin
                    last_owner = g[1];
                    start_c = c;
                end
            end
            for (int n = 0; n < 2; n++) begin
                if (bus_ack(n) | bus_err(n)) begin
                    exp_err = (r_addr[n] >> (AW + 2)) != 0;
                    chk("resp_owner", 32'({g[n], act[n]}), 32'b11);
                    chk("resp_lat", 32'(c - start_c), 1);
                    chk("resp_kind", 32'({bus_ack(n), bus_err(n)}), exp_err ? 32'b01 : 32'b10);
                    if (!exp_err) begin
                        if (r_we[n]) model_write(r_addr[n], r_sel[n], r_din[n]);
                        else chk("rand_rd_data", bus_dout(n), ref_mem[r_addr[n][5:2]]);
                    end
                    act[n] = 1'b0;
                    drive(n, 0, 0, 0, 4'h0, 32'h0, 32'h0);
                end
            end
            for (int n = 0; n < 2; n++) begin
                if (!act[n] && c < 400 && $urandom_range(0, 2) != 0) begin
                    r_we[n]  = 1'($urandom_range(0, 1));
                    r_sel[n] = 4'($urandom_range(1, 15));
                    idx      = int'($urandom_range(0, 15));
                    a        = (32'(idx) << 2) | 32'($urandom_range(0, 3));
                    if ($urandom_range(0, 7) == 0) a = a | (32'($urandom_range(1, 255)) << 12);
                    r_addr[n] = a;
                    r_din[n]  = $urandom;
                    act[n]    = 1'b1;
                    drive(n, 1, 1, r_we[n], r_sel[n], r_addr[n], r_din[n]);
                end
            end
            prev_grant = g;
            prev_req   = act;
        end
        chk("rand_drain", 32'(act), 0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/sd_buf_arbiter.md
Name: sd_buf_arbiter

Overview:
- Arbitrates one single-port 1024x32 SD DMA buffer RAM between two Wishbone-style masters.
  - m0 is the CPU-side bridge.
  - m1 is the SD controller DMA master.
- Sequences each access as an arbitrate/access/acknowledge transaction.
- Returns registered read data, per-master acks, and an error response for out-of-range addresses.
- Sits between the SD controller DMA port and the buffer RAM, replacing the dual-port buffer arrangement.

Parameters:
- AW, 10: word-address width of the RAM. The RAM holds 2^AW words.
- FIXED_PRIO, 0: 0 selects round-robin arbitration. 1 makes m0 win every contention.

Ports:
- clkCPU  in  1  clock; all state updates on the rising edge.
- globlRst  in  1  reset, asynchronous, active-low.
- m0_cyc, m0_stb, m0_we  in  1 each  master 0 cycle, strobe and write enable.
- m0_sel  in  4  master 0 byte lane select.
- m0_addr  in  32  master 0 byte address.
- m0_din  in  32  master 0 write data.
- m0_dout  out  32  master 0 read data.
- m0_ack, m0_err  out  1 each  master 0 acknowledge and error.
- m1_*  same set and widths as m0_*, for master 1.
- ram_en  out  1  RAM enable.
- ram_we  out  4  RAM byte write enables.
- ram_addr  out  AW  RAM word address.
- ram_wdata  out  32  RAM write data.
- ram_rdata  in  32  RAM read data; valid one cycle after ram_en.
- grant  out  2  one-hot owner of the current transaction; 00 when idle.
- busy  out  1  high when state is not IDLE.

Behaviour:
- Request definition: reqN = mN_cyc & mN_stb.
- Range check: a request is in-range when mN_addr[31:AW+2] == 0.
- State machine (3 states: IDLE, ACCESS, ACK):
  - IDLE: if no request, stay.
    - If exactly one request, grant it.
    - If both request and FIXED_PRIO=1, grant m0.
    - If both request and FIXED_PRIO=0, grant the master that is not last_grant.
    - Grant, we, sel, addr and din of the winner are latched into registers; go to ACCESS.
  - ACCESS: go to ACK.
    - If the latched address is in-range: ram_en=1, ram_addr=latched addr[AW+1:2], ram_wdata=latched din.
    - ram_we = latched sel when latched we=1, else 0000.
    - If out-of-range: ram_en=0, ram_we=0000, and err_flag is set.
  - ACK: go to IDLE; last_grant <= grant.
    - Read data: mN_dout <= ram_rdata captured at the end of ACCESS, shown in ACK.
    - Response: granted mN_ack = ~err_flag & mN_cyc; granted mN_err = err_flag & mN_cyc.
- All RAM-side outputs are driven from latched registers, so they stay stable during ACCESS regardless of master input changes.
- Timing and throughput:
  - Latency from a request seen in IDLE to ack is 2 cycles.
  - One transaction completes per 3 cycles.
  - A master holding a request after its ack is treated as a new request in the next IDLE.
- mN_ack and mN_err are single-cycle pulses and are never asserted for the non-granted master.
- mN_dout holds its last value outside ACK; its reset value is 0.
- Abort: if the granted master drops cyc during ACCESS, the RAM access still completes (the write is committed). The ack/err is suppressed in ACK.
- Reset (asynchronous, any state including mid-transaction):
  - state=IDLE, grant=00, last_grant=m1 (so m0 wins the first tie), err_flag=0.
  - All acks/errs=0, ram_en=0, ram_we=0000, ram_addr=0, ram_wdata=0, busy=0, mN_dout=0.
  - A write in ACCESS when reset asserts is not guaranteed to complete.
- Sub-word writes: only the lanes selected by sel are written. On reads, sel is ignored and the full word is returned.

Test Plan:
- Reset, then m0 write addr 0x00000010, sel 1111, data 0xDEADBEEF; then m0 read 0x10.
  - Required: ram_we=1111 at ram_addr=4; ack 2 cycles after each request; read m0_dout=0xDEADBEEF.
- m1 write sel 0010, data 0x0000AB00, to a word holding 0x11223344; then read.
  - Required: read returns 0x1122AB44.
- Both masters request continuously with FIXED_PRIO=0.
  - Required: grants alternate m0, m1, m0, m1; exactly one ack every 3 cycles; m0 first after reset.
- Same contention with FIXED_PRIO=1.
  - Required: m1 is never granted while m0 requests.
- m0 read at 0x00001000.
  - Required: ram_en stays 0; m0_err pulses 2 cycles later; m0_ack=0.
- m1 write with m1_cyc dropped in ACCESS.
  - Required: RAM written, no m1_ack.
- Separately, globlRst asserted in ACCESS.
  - Required: outputs reset immediately, without a clock edge.
